// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with optional multiply-accumulate (MADD/MSUB) into a HI/LO base.
module ex_muldiv_iter #(
  parameter int WIDTH  = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]       op_r;
  logic             sa_r, sb_r;
  logic [WIDTH-1:0] rem, q, dsr, base_hi, base_lo;
  logic [CW-1:0]    cnt;

  // Handshake: a start is taken only in IDLE/DONE with cancel_i low; there is
  // no backpressure, valid_o is a one-cycle strobe the consumer must capture.
  logic in_signed, in_div, div_zero, accept, last;
  assign in_signed = ~op_i[0];
  assign in_div    = (op_i[2:1] == 2'b01);
  assign div_zero  = in_div && (b_i == '0);
  assign accept    = start_i && !cancel_i && (state == IDLE || state == DONE)
                     && (ACC_EN || !op_i[2]);
  assign last      = (cnt == CW'(WIDTH - 1));

  logic is_div_r, is_acc_r, is_sub_r;
  assign is_div_r = (op_r[2:1] == 2'b01);
  assign is_acc_r = op_r[2];
  assign is_sub_r = op_r[2] & op_r[1];

  // One iteration of the datapath; divide shifts the dividend out of q's top
  // while multiply shifts the product in at rem's top.
  logic [WIDTH:0]   shifted, diff, sum;
  logic [WIDTH-1:0] rem_nx, q_nx;
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
    sum     = {1'b0, rem} + ({(WIDTH+1){q[0]}} & {1'b0, dsr});
    rem_nx  = rem;
    q_nx    = q;
    if (is_div_r) begin
      if (!diff[WIDTH]) begin
        rem_nx = diff[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b1};
      end else begin
        rem_nx = shifted[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_nx = sum[WIDTH:1];
      q_nx   = {sum[0], q[WIDTH-1:1]};
    end
  end

  function automatic logic [2*WIDTH-1:0] fix_up(input logic div, input logic sa,
                                                input logic sb, input logic [WIDTH-1:0] h,
                                                input logic [WIDTH-1:0] l);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   qq, rr;
    qq = (sa ^ sb) ? -l : l;
    rr = sa ? -h : h;
    p  = (sa ^ sb) ? -{h, l} : {h, l};
    return div ? {rr, qq} : p;
  endfunction

  logic [2*WIDTH-1:0] calc_res, prod_res, acc_res;
  assign calc_res = fix_up(is_div_r, sa_r, sb_r, rem_nx, q_nx);
  assign prod_res = fix_up(1'b0, sa_r, sb_r, rem, q);
  assign acc_res  = is_sub_r ? ({base_hi, base_lo} - prod_res)
                             : ({base_hi, base_lo} + prod_res);

  logic               load;
  logic [2*WIDTH-1:0] load_val;
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = calc_res;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nx = IDLE;
        if (accept) begin
          state_nx = div_zero ? DONE : CALC;
          if (div_zero) begin
            load     = 1'b1;
            load_val = {a_i, {WIDTH{1'b1}}};
          end
        end
      end
      CALC: begin
        if (cancel_i) state_nx = IDLE;
        else if (last) begin
          state_nx = is_acc_r ? ACC : DONE;
          load     = !is_acc_r;
        end
      end
      ACC: begin
        state_nx = cancel_i ? IDLE : DONE;
        load     = !cancel_i;
        load_val = acc_res;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r    <= '0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      rem     <= '0;
      q       <= '0;
      dsr     <= '0;
      base_hi <= '0;
      base_lo <= '0;
      cnt     <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      if (accept) begin
        op_r    <= op_i;
        sa_r    <= in_signed & a_i[WIDTH-1];
        sb_r    <= in_signed & b_i[WIDTH-1];
        rem     <= '0;
        q       <= (in_signed & a_i[WIDTH-1]) ? -a_i : a_i;
        dsr     <= (in_signed & b_i[WIDTH-1]) ? -b_i : b_i;
        base_hi <= hi_i;
        base_lo <= lo_i;
        cnt     <= '0;
      end else if (state == CALC) begin
        rem <= rem_nx;
        q   <= q_nx;
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        hi_o <= load_val[2*WIDTH-1:WIDTH];
        lo_o <= load_val[WIDTH-1:0];
      end
    end
  end

  assign busy_o  = (state == CALC) || (state == ACC);
  assign valid_o = (state == DONE);
  assign state_o = state;

endmodule

// File: doc/ex_muldiv_iter.md
EX_MULDIV_ITER -- requirements
Module: ex_muldiv_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width, which is also the width of hi/lo.
REQ-002 SHALL have parameter ACC_EN, default 1: when 1, the MADD/MADDU/MSUB/MSUBU ops are enabled.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1: request to begin an operation.
REQ-006 SHALL have port op_i, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-007 SHALL have port a_i, input, WIDTH: multiplicand or dividend.
REQ-008 SHALL have port b_i, input, WIDTH: multiplier or divisor.
REQ-009 SHALL have port hi_i, input, WIDTH: current HI, used as the accumulate base.
REQ-010 SHALL have port lo_i, input, WIDTH: current LO, used as the accumulate base.
REQ-011 SHALL have port cancel_i, input, 1: flush; aborts any operation in flight.
REQ-012 SHALL have port busy_o, output, 1: high while in CALC or ACC.
REQ-013 SHALL have port valid_o, output, 1: single-cycle result strobe.
REQ-014 SHALL have port hi_o, output, WIDTH: result HI (product high half, or remainder).
REQ-015 SHALL have port lo_o, output, WIDTH: result LO (product low half, or quotient).

Function
REQ-016 SHALL implement FSM states IDLE, CALC, ACC, DONE; valid_o SHALL be 1 only in DONE.
REQ-017 SHALL accept start_i only in IDLE or DONE with cancel_i=0; start_i in CALC/ACC SHALL be ignored.
REQ-018 When ACC_EN=0, start_i with op_i[2]=1 SHALL NOT be accepted, and the state SHALL be unchanged.
REQ-019 On acceptance (cycle T) SHALL latch op_i, the magnitudes of a_i/b_i (two's-complement magnitude for signed ops, raw for unsigned), the result signs, and hi_i/lo_i.
REQ-020 Multiply SHALL be radix-2 shift-add and divide radix-2 restoring, one bit per cycle; CALC SHALL last exactly WIDTH cycles (T+1..T+WIDTH).
REQ-021 MULT/MULTU/DIV/DIVU: CALC SHALL go to DONE; valid_o=1 in cycle T+WIDTH+1.
REQ-022 MADD*/MSUB*: CALC SHALL go to ACC at T+WIDTH+1, then DONE; valid_o=1 in cycle T+WIDTH+2.
REQ-023 DIV/DIVU with b_i=0 SHALL skip CALC and go IDLE/DONE->DONE with valid_o=1 at T+1, giving lo_o=all ones and hi_o=a_i.
REQ-024 Multiply result SHALL be {hi_o,lo_o} = the full 2*WIDTH-bit product, signed or unsigned per op.
REQ-025 MADD*/MSUB* SHALL give {hi_o,lo_o} = {hi_i,lo_i} +/- product (using hi_i/lo_i latched at T), modulo 2^(2*WIDTH).
REQ-026 Divide SHALL return quotient in lo_o, truncated toward zero, and remainder in hi_o; remainder sign SHALL equal the dividend sign and quotient sign SHALL be a^b.
REQ-027 DIV of the most-negative value by -1 SHALL yield lo_o=the most-negative value and hi_o=0, with no exception.
REQ-028 Sign fix-up SHALL be applied when hi_o/lo_o are loaded on entry to DONE; hi_o/lo_o SHALL change only then and otherwise hold.
REQ-029 DONE with no new start SHALL go to IDLE; a start accepted in DONE SHALL go directly to CALC (back-to-back), with valid_o=1 for that cycle only.
REQ-030 cancel_i=1 in CALC, ACC or DONE SHALL force IDLE next cycle with no valid_o for the cancelled op and hi_o/lo_o unchanged.
REQ-031 cancel_i=1 together with start_i SHALL suppress acceptance.
REQ-032 An iteration counter of width clog2(WIDTH)+1 SHALL be cleared at acceptance.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, counter 0, busy_o=0, valid_o=0, hi_o=0, lo_o=0, including mid-operation.
REQ-034 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-035 MULT a=0xFFFFFFFE, b=3 -> valid_o at T+33; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; busy_o high T+1..T+32.
REQ-036 DIVU 100/7 -> lo_o=14, hi_o=2; DIV 0xFFFFFFF9/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-037 DIV a=5, b=0 -> valid_o at T+1; lo_o=0xFFFFFFFF, hi_o=5. Also DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-038 MADDU hi_i=0, lo_i=0xFFFFFFFF, a=1, b=1 -> valid_o at T+34; hi_o=1, lo_o=0.
REQ-039 MSUB hi_i=0, lo_i=0, a=2, b=3 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
REQ-040 MULTU started, cancel_i at T+10 -> busy_o=0 at T+11, no valid_o, hi_o/lo_o unchanged; back-to-back start in DONE accepted; rst=0 mid-CALC -> all outputs 0 without waiting for a clock edge.
